// File: rtl/ie_mdu_pkg.sv
// Shared types for the IE-stage RV32M multiply/divide sequencer.
package ie_mdu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude extraction on operands, sign restore on results.
// Purely combinational, no handshake.
module mdu_sign_fix
  import ie_mdu_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/ie_mdu_ctrl.sv
// Iterative RV32M mul/div sequencer: XLEN+1 cycles start->done (1 cycle for special cases with MDU_EARLY_OUT_EN).
// No backpressure: stall freezes IF/ID/IE while an op runs; starts outside IDLE are dropped.
module ie_mdu_ctrl
  import ie_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  mdu_op_e    op_in, op_q;

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, mul_nxt, div_nxt, prod_fix;
  logic [XLEN-1:0]   b_q, mag1, mag2, quo_fix, rem_fix, fin_calc, fin_q, res_q;
  logic [XLEN:0]     mul_sum, div_sh, div_dif;
  logic              neg_a_q, neg_b_q, dz_q, ovf_q;
  logic              sgn1, sgn2, neg1, neg2, dz_in, ovf_in, accept, special;
  logic              q_bit, res_neg, last_iter;

  assign op_in  = mdu_op_e'(op);
  assign sgn1   = (op_in == MULH) || (op_in == MULHSU) || (op_in == DIV) || (op_in == REM);
  assign sgn2   = (op_in == MULH) || (op_in == DIV) || (op_in == REM);
  assign neg1   = sgn1 & r1[XLEN-1];
  assign neg2   = sgn2 & r2[XLEN-1];
  assign dz_in  = (r2 == '0);
  assign ovf_in = sgn1 & sgn2 & (r1 == MIN_NEG) & (r2 == '1);
  assign accept = (state_q == IDLE) & start & ~flush;

  mdu_sign_fix #(.W(XLEN)) u_mag1 (.din(r1), .neg(neg1), .dout(mag1));
  mdu_sign_fix #(.W(XLEN)) u_mag2 (.din(r2), .neg(neg2), .dout(mag2));

`ifdef MDU_EARLY_OUT_EN
  // Results for operand patterns that need no iteration at all.
  logic [XLEN-1:0] sp_res;
  assign special = (r1 == '0) | dz_in | (op[2] & ovf_in);
  always_comb begin
    sp_res = '0;
    if (op[2]) begin
      if (dz_in)       sp_res = op[1] ? r1 : '1;
      else if (ovf_in) sp_res = op[1] ? '0 : MIN_NEG;
    end
  end
`else
  assign special = 1'b0;
`endif

  // acc = {hi, lo}: product accumulator / multiplier for MUL*, remainder / quotient for DIV*.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
  assign div_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign div_dif = div_sh - {1'b0, b_q};
  assign q_bit   = ~div_dif[XLEN];
  assign div_nxt = {q_bit ? div_dif[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], q_bit};
  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

  // Final result is taken from the value the last iteration is about to write.
  assign res_neg = neg_a_q ^ neg_b_q;
  mdu_sign_fix #(.W(2*XLEN)) u_prod (.din(acc_nxt), .neg(res_neg), .dout(prod_fix));
  mdu_sign_fix #(.W(XLEN)) u_quo (.din(acc_nxt[XLEN-1:0]), .neg(res_neg), .dout(quo_fix));
  mdu_sign_fix #(.W(XLEN)) u_rem (.din(acc_nxt[2*XLEN-1:XLEN]), .neg(neg_a_q), .dout(rem_fix));

  always_comb begin
    fin_calc = '0;
    if (!op_q[2])      fin_calc = (op_q == MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (!op_q[1]) fin_calc = dz_q ? '1 : (ovf_q ? MIN_NEG : quo_fix);
    else               fin_calc = ovf_q ? '0 : rem_fix;
  end

  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (flush) state_d = IDLE;
               else if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      fin_q   <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        cnt_q   <= '0;
        acc_q   <= {{XLEN{1'b0}}, mag1};
        b_q     <= mag2;
        neg_a_q <= neg1;
        neg_b_q <= neg2;
        dz_q    <= op[2] & dz_in;
        ovf_q   <= op[2] & ovf_in;
`ifdef MDU_EARLY_OUT_EN
        if (special) fin_q <= sp_res;
`endif
      end
      if (state_q == CALC) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_iter) fin_q <= fin_calc;
      end
      if ((state_q == DONE) && !flush) res_q <= fin_q;
    end
  end

  assign stall  = (start & (state_q == IDLE)) | (state_q == CALC);
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE) & ~flush;
  assign result = done ? fin_q : res_q;

endmodule

// File: tb/tb_ie_mdu_ctrl.sv
// Directed-vector bench for ie_mdu_ctrl plus hand-written flush, ignored-start and reset sequences.
module tb_ie_mdu_ctrl;
  import ie_mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] r1, r2;
  logic        stall, busy, done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ie_mdu_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .r1(r1), .r2(r2),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    sp = (a == 32'd0) || (b == 32'd0) ||
         (((o == DIV) || (o == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    return (EARLY && sp) ? 1 : 33;
  endfunction

  // Starts one op at cycle 0; optionally fires a stray start at cycle poke_k.
  task automatic run_vec(input logic [2:0] vop, input logic [31:0] va, input logic [31:0] vb,
                         input int poke_k, output int lat, output logic [31:0] res,
                         output int stall_n, output int busy_n);
    lat = -1; res = 32'd0; stall_n = 0; busy_n = 0;
    @(posedge clk); #1;
    start = 1'b1; op = vop; r1 = va; r2 = vb;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
      @(posedge clk); #1;
      if (k + 1 == poke_k) begin
        start = 1'b1; op = MUL; r1 = 32'd3; r2 = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_vec(input string nm, input logic [2:0] vop, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] vexp, input int poke_k);
    int lat, sn, bn, el;
    logic [31:0] res;
    el = exp_lat(vop, va, vb);
    run_vec(vop, va, vb, poke_k, lat, res, sn, bn);
    chk({nm, "_result"}, res, vexp);
    chk({nm, "_done_cycle"}, lat, el);
    chk({nm, "_stall_cycles"}, sn, el);
    chk({nm, "_busy_cycles"}, bn, el - 1);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    last_res = vexp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; r1 = 32'd0; r2 = 32'd0;
    last_res = 32'd0;

    vecs[0]  = '{MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5]  = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{DIVU,   32'd13,        32'd0,         32'hFFFF_FFFF};
    vecs[7]  = '{REMU,   32'd13,        32'd0,         32'd13};
    vecs[8]  = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[9]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[10] = '{DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    vecs[12] = '{DIVU,   32'd100,       32'd7,         32'd14};
    vecs[13] = '{REMU,   32'd100,       32'd7,         32'd2};
    vecs[14] = '{MUL,    32'h1234_5678, 32'h10,        32'h2345_6780};
    vecs[15] = '{MULHU,  32'h1234_5678, 32'h10,        32'h0000_0001};
    vecs[16] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[17] = '{MUL,    32'd0,         32'd5,         32'd0};
    vecs[18] = '{DIV,    32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD};
    vecs[19] = '{REM,    32'd20,        32'hFFFF_FFFA, 32'd2};
    vecs[20] = '{DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[21] = '{MULHSU, 32'd7,         32'hFFFF_FFFF, 32'd6};

    #12;
    chk("reset_busy",   {31'd0, busy},  32'd0);
    chk("reset_done",   {31'd0, done},  32'd0);
    chk("reset_stall",  {31'd0, stall}, 32'd0);
    chk("reset_result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      check_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, -1);

    // Flush in the middle of a DIVU: no done, result keeps the previous value.
    @(posedge clk); #1;
    start = 1'b1; op = DIVU; r1 = 32'd1000; r2 = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after",  {31'd0, busy},  32'd0);
    chk("flush_stall_after", {31'd0, stall}, 32'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("flush_no_done", dn, 32'd0);
    chk("flush_result_held", result, last_res);

    // Start together with flush in IDLE is not accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = DIV; r1 = 32'd50; r2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("startflush_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("startflush_no_done", dn, 32'd0);
    chk("startflush_result_held", result, last_res);

    // A start pulse during CALC must not queue a second op.
    check_vec("ignored_start", DIVU, 32'd100, 32'd7, 32'd14, 5);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("ignored_start_no_extra_done", dn, 32'd0);

    // Asynchronous reset in the middle of an op.
    @(posedge clk); #1;
    start = 1'b1; op = MUL; r1 = 32'd7; r2 = 32'hFFFF_FFFD;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy",   {31'd0, busy},  32'd0);
    chk("midreset_stall",  {31'd0, stall}, 32'd0);
    chk("midreset_done",   {31'd0, done},  32'd0);
    chk("midreset_result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_vec("after_reset", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
